// File: rtl/reset_sequencer.sv
// Lock-qualified power-on reset sequencer: releases NUM_CH active-low reset
// domains one at a time, in order, and re-runs on lock loss or software request.
module reset_sequencer #(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = 16,
  parameter int LOCK_FILTER = 8,
  parameter int INIT_HOLD   = 10,
  parameter int STAGE_GAP   = 4
) (
  input  logic              SYSCLK,
  input  logic              SYSRESET,
  input  logic              LOCK,
  input  logic              SW_RST_REQ,
  output logic [NUM_CH-1:0] NRST_OUT,
  output logic              SEQ_DONE,
  output logic [1:0]        STATE
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] LF_T   = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] IH_T   = CNT_W'(INIT_HOLD - 1);
  localparam logic [CNT_W-1:0] SG_T   = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    WAIT  = 2'd1,
    STAGE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [NUM_CH-1:0]  nrst, nrst_nx;
  logic               done, done_nx;

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      state <= HOLD;
      cnt   <= '0;
      idx   <= '0;
      nrst  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      nrst  <= nrst_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    nrst_nx  = nrst;
    done_nx  = done;

    case (state)
      HOLD: begin
        nrst_nx = '0;
        done_nx = 1'b0;
        idx_nx  = '0;
        if (SW_RST_REQ || !LOCK) begin
          cnt_nx = '0;
        end else if (cnt == LF_T) begin
          state_nx = WAIT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT: begin
        if (cnt == IH_T) begin
          nrst_nx = NUM_CH'(1);
          cnt_nx  = '0;
          idx_nx  = IDX_W'(1);
          if (NUM_CH == 1) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = STAGE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STAGE: begin
        if (cnt == SG_T) begin
          // Shifting a 1 in keeps the release pattern thermometer-coded by construction.
          nrst_nx = (nrst << 1) | NUM_CH'(1);
          cnt_nx  = '0;
          if (idx == LAST_I) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE: begin
        nrst_nx = '1;
        done_nx = 1'b1;
      end
      default: state_nx = HOLD;
    endcase

    // Abort overrides any progression outside HOLD; HOLD handles its own clearing.
    if ((state != HOLD) && (!LOCK || SW_RST_REQ)) begin
      state_nx = HOLD;
      cnt_nx   = '0;
      idx_nx   = '0;
      nrst_nx  = '0;
      done_nx  = 1'b0;
    end
  end

  assign NRST_OUT = nrst;
  assign SEQ_DONE = done;
  assign STATE    = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes (with edge number),
// monitors pop and compare whenever a DUT output changes.
module tb_reset_sequencer;

  typedef struct {
    int         cyc;
    logic [2:0] nrst;
    logic       done;
    logic [1:0] st;
  } ev_t;

  logic       SYSCLK = 1'b0;
  logic       rst0, lock0, sw0;
  logic [2:0] nrst0;
  logic       done0;
  logic [1:0] st0;
  logic       rst1, lock1, sw1;
  logic [0:0] nrst1;
  logic       done1;
  logic [1:0] st1;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  ev_t q0[$];
  ev_t q1[$];
  logic [5:0] prev0, prev1;

  reset_sequencer dut0 (
    .SYSCLK(SYSCLK), .SYSRESET(rst0), .LOCK(lock0), .SW_RST_REQ(sw0),
    .NRST_OUT(nrst0), .SEQ_DONE(done0), .STATE(st0)
  );

  reset_sequencer #(.NUM_CH(1), .LOCK_FILTER(1), .INIT_HOLD(1)) dut1 (
    .SYSCLK(SYSCLK), .SYSRESET(rst1), .LOCK(lock1), .SW_RST_REQ(sw1),
    .NRST_OUT(nrst1), .SEQ_DONE(done1), .STATE(st1)
  );

  always #5 SYSCLK = ~SYSCLK;
  always @(posedge SYSCLK) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge SYSCLK);
    #1;
  endtask

  task automatic push0(input int c, input logic [2:0] n, input logic d, input logic [1:0] s);
    ev_t e;
    e.cyc = c; e.nrst = n; e.done = d; e.st = s;
    q0.push_back(e);
  endtask

  task automatic push1(input int c, input logic n, input logic d, input logic [1:0] s);
    ev_t e;
    e.cyc = c; e.nrst = {2'b00, n}; e.done = d; e.st = s;
    q1.push_back(e);
  endtask

  // Default-parameter sequence with E1 = b+1: WAIT@E8, ch0@E18, ch1@E22, ch2+done@E26.
  task automatic push_seq(input int b, input int n);
    if (n > 0) push0(b + 8,  3'b000, 1'b0, 2'd1);
    if (n > 1) push0(b + 18, 3'b001, 1'b0, 2'd2);
    if (n > 2) push0(b + 22, 3'b011, 1'b0, 2'd2);
    if (n > 3) push0(b + 26, 3'b111, 1'b1, 2'd3);
  endtask

  task automatic cmp_ev(input string name, input ev_t e, input logic [2:0] n,
                        input logic d, input logic [1:0] s);
    checks++;
    if (e.cyc != cyc || e.nrst != n || e.done != d || e.st != s) begin
      errors++;
      $display("FAIL %s: got edge=%0d nrst=%b done=%b state=%0d, expected edge=%0d nrst=%b done=%b state=%0d",
               name, cyc, n, d, s, e.cyc, e.nrst, e.done, e.st);
    end
  endtask

  always @(negedge SYSCLK) begin
    if (mon_en) begin
      ev_t e;
      // thermometer coding and done/all-released consistency on every cycle
      checks++;
      if (((nrst0 & (nrst0 + 3'd1)) != 3'd0) || (done0 != &nrst0)) begin
        errors++;
        $display("FAIL thermo0: got nrst=%b done=%b at edge %0d, required thermometer code with done=&nrst",
                 nrst0, done0, cyc);
      end
      if ({nrst0, done0, st0} != prev0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut0_unexpected: got nrst=%b done=%b state=%0d at edge %0d, expected no change",
                   nrst0, done0, st0, cyc);
        end else begin
          e = q0.pop_front();
          cmp_ev("dut0_event", e, nrst0, done0, st0);
        end
        prev0 = {nrst0, done0, st0};
      end
      if ({3'b000, nrst1, done1, st1} != prev1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1_unexpected: got nrst=%b done=%b state=%0d at edge %0d, expected no change",
                   nrst1, done1, st1, cyc);
        end else begin
          e = q1.pop_front();
          cmp_ev("dut1_event", e, {2'b00, nrst1}, done1, st1);
        end
        prev1 = {nrst1, done1, st1};
      end
    end
  end

  initial begin
    int b;
    rst0 = 1'b1; lock0 = 1'b1; sw0 = 1'b0;
    rst1 = 1'b1; lock1 = 1'b1; sw1 = 1'b0;
    step(10);

    checks++;
    if (nrst0 !== 3'b000 || done0 !== 1'b0 || st0 !== 2'd0) begin
      errors++;
      $display("FAIL reset0: got nrst=%b done=%b state=%0d, expected 000 0 0", nrst0, done0, st0);
    end
    checks++;
    if (nrst1 !== 1'b0 || done1 !== 1'b0 || st1 !== 2'd0) begin
      errors++;
      $display("FAIL reset1: got nrst=%b done=%b state=%0d, expected 0 0 0", nrst1, done1, st1);
    end
    prev0 = {nrst0, done0, st0};
    prev1 = {nrst1, done1, st1};
    mon_en = 1'b1;

    // Power-up with steady lock; single-channel instance goes 0 -> 1 -> 3 at E1, E2
    b = cyc;
    push_seq(b, 4);
    push1(b + 1, 1'b0, 1'b0, 2'd1);
    push1(b + 2, 1'b1, 1'b1, 2'd3);
    rst0 = 1'b0; rst1 = 1'b0;
    step(30);

    // SW_RST_REQ pulse of 3 cycles in DONE
    b = cyc;
    sw0 = 1'b1;
    push0(b + 1, 3'b000, 1'b0, 2'd0);
    step(3);
    sw0 = 1'b0;
    push_seq(cyc, 4);
    step(30);

    // Lock loss in DONE, then lock loss in STAGE with 011
    b = cyc;
    lock0 = 1'b0;
    push0(b + 1, 3'b000, 1'b0, 2'd0);
    step(1);
    lock0 = 1'b1;
    b = cyc;
    push_seq(b, 3);
    step(22);
    lock0 = 1'b0;
    push0(b + 23, 3'b000, 1'b0, 2'd0);
    step(1);
    lock0 = 1'b1;
    push_seq(cyc, 4);
    step(30);

    // SYSRESET together with SW_RST_REQ and LOCK=0 in DONE
    b = cyc;
    rst0 = 1'b1; sw0 = 1'b1; lock0 = 1'b0;
    push0(b + 1, 3'b000, 1'b0, 2'd0);
    step(3);
    rst0 = 1'b0; sw0 = 1'b0; lock0 = 1'b1;

    // Single-cycle LOCK glitch at E5 in HOLD restarts the filter
    step(4);
    lock0 = 1'b0;
    step(1);
    lock0 = 1'b1;
    push_seq(cyc, 4);
    step(30);

    mon_en = 1'b0;
    while (q0.size() != 0) begin
      ev_t e;
      e = q0.pop_front();
      checks++; errors++;
      $display("FAIL dut0_missing: got no change, expected edge=%0d nrst=%b done=%b state=%0d",
               e.cyc, e.nrst, e.done, e.st);
    end
    while (q1.size() != 0) begin
      ev_t e;
      e = q1.pop_front();
      checks++; errors++;
      $display("FAIL dut1_missing: got no change, expected edge=%0d nrst=%b done=%b state=%0d",
               e.cyc, e.nrst, e.done, e.st);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised power-on reset sequencer that releases NUM_CH active-low reset domains one at a time, in fixed order, after the system reset clears and the clock source reports stable lock. Sits between the board-level SYSCLK/SYSRESET source and the processor subsystem reset inputs: device reset, JTAG TRSTB, DDR training and peripheral resets. It replaces a single fixed-length reset pulse with a staggered, lock-qualified sequence that can be re-run at any time. It is synthesisable and also instantiated directly in the simulation benches.

## Interface
- NUM_CH, 3: number of reset domains; ≥1
- CNT_W, 16: width of the shared cycle counter; must hold max(LOCK_FILTER, INIT_HOLD, STAGE_GAP)−1
- LOCK_FILTER, 8: consecutive cycles LOCK must be high before sequencing starts; ≥1
- INIT_HOLD, 10: cycles from lock qualification to release of channel 0; ≥1
- STAGE_GAP, 4: cycles between successive channel releases; ≥1

- SYSCLK  in  1  sole clock, rising edge
- SYSRESET  in  1  reset; synchronous, active-high; one clock, all state sampled on SYSCLK
- LOCK  in  1  clock-source lock/stable indication, synchronous to SYSCLK
- SW_RST_REQ  in  1  level request to restart the whole sequence
- NRST_OUT  out  NUM_CH  per-domain reset, active-low; bit 0 released first
- SEQ_DONE  out  1  high when all domains are released
- STATE  out  2  current FSM state: 0 HOLD, 1 WAIT, 2 STAGE, 3 DONE

## Operation
- All outputs are registered. On SYSRESET=1 at an edge: NRST_OUT=0, SEQ_DONE=0, STATE=HOLD, cnt=0, channel index=0.
- HOLD: all NRST_OUT low.
  - LOCK=1: cnt increments.
  - LOCK=0: cnt clears.
  - cnt==LOCK_FILTER−1 with LOCK=1: go to WAIT, cnt=0.
- WAIT: cnt increments.
  - cnt==INIT_HOLD−1: NRST_OUT[0]=1, cnt=0, index=1.
  - Next state is STAGE, or DONE if NUM_CH==1.
- STAGE: cnt increments.
  - cnt==STAGE_GAP−1: NRST_OUT[index]=1, index++, cnt=0.
  - When the released bit is NUM_CH−1: go to DONE and set SEQ_DONE=1 on the same edge.
- DONE: holds all NRST_OUT high and SEQ_DONE=1 indefinitely.
- Abort: LOCK=0 or SW_RST_REQ=1 sampled in WAIT, STAGE or DONE. On the next edge: all NRST_OUT=0, SEQ_DONE=0, STATE=HOLD, cnt=0, index=0.
  - While SW_RST_REQ stays high in HOLD, cnt is held at 0.
  - The filter restarts from zero once SW_RST_REQ drops.
- Priority at any edge: SYSRESET > abort (LOCK=0 / SW_RST_REQ) > normal progression.
- NRST_OUT is always thermometer-coded: bit k high implies all bits below k are high.
- No channel is ever released out of order or reasserted individually.
- cnt never exceeds its terminal value. Counters do not wrap.

## Timing
- Let E1 be the first edge with SYSRESET=0. Assume LOCK=1 and SW_RST_REQ=0 from E1 onward.
  - Channel k is high after edge E(LOCK_FILTER + INIT_HOLD + k·STAGE_GAP).
  - SEQ_DONE rises on the same edge as NRST_OUT[NUM_CH−1].
- Defaults: NRST_OUT[0] at E18, [1] at E22, [2] at E26; SEQ_DONE at E26. Total latency 26 cycles.
- Abort latency: exactly one edge, from the sampled LOCK=0 / SW_RST_REQ=1 to all outputs low.
- STATE changes on the same edge as the associated output changes.
- SYSRESET mid-sequence: outputs return to their reset values at that edge. No partial release persists.

## Test plan
- Defaults, SYSRESET high 10 cycles then low, LOCK=1 steady -> NRST_OUT 000→001 at E18, 011 at E22, 111 at E26; SEQ_DONE=1 at E26; STATE sequence 0,1,2,3.
- LOCK glitches low for 1 cycle at E5 while in HOLD -> filter restarts; NRST_OUT[0] rises 18 edges after the glitch ends (E6 counts as new E1).
- In STAGE with NRST_OUT=011, drop LOCK for 1 cycle -> next edge NRST_OUT=000, SEQ_DONE=0, STATE=0; full 26-cycle re-sequence after LOCK returns.
- In DONE, pulse SW_RST_REQ for 3 cycles -> NRST_OUT=000 one edge after first sample; sequence restarts after release, reaching 111 26 edges later.
- NUM_CH=1, LOCK_FILTER=1, INIT_HOLD=1 -> NRST_OUT[0] and SEQ_DONE both rise at E2; STATE goes 0→1→3, never 2.
- SYSRESET asserted the same edge as SW_RST_REQ and LOCK=0 in DONE -> reset values at that edge; check thermometer invariant on every cycle throughout.
